// File: rtl/udma_i2c_cmd_arb.sv
// Round-robin arbiter that shares one I2C command channel among N_REQ sources,
// locking the channel to a winner until its STOP word. Optional lock watchdog: I2C_ARB_TIMEOUT_EN.
module udma_i2c_cmd_arb #(
  parameter int         N_REQ          = 2,
  parameter logic [3:0] STOP_OP        = 4'h2,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [32*N_REQ-1:0]  req_cmd_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [31:0]          cmd_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [2:0]           owner_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t      state;
  logic        ld;
  logic [7:0]  valid_pad;
  logic [2:0]  winner;
  logic        winner_found;
  logic [3:0]  scan_idx;
  logic [2:0]  grant_idx;
  logic        grant_valid;
  logic [31:0] grant_word;
  logic        accept;
  logic        stop_word;
  logic        timeout_fire;

  // Configurations outside the supported range elaborate into this empty marker block.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_invalid_cfg
  end

  assign ld        = !cmd_valid_o || cmd_ready_i;
  assign valid_pad = 8'(req_valid_i);

  // Priority scan starts just after the last owner and wraps modulo N_REQ.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = {1'b0, owner_o} + 4'(k);
      if (scan_idx >= 4'(N_REQ)) begin
        scan_idx = scan_idx - 4'(N_REQ);
      end
      if (!winner_found && valid_pad[scan_idx[2:0]]) begin
        winner_found = 1'b1;
        winner       = scan_idx[2:0];
      end
    end
  end

  assign grant_idx   = (state == ST_LOCKED) ? owner_o : winner;
  assign grant_valid = (state == ST_LOCKED) ? valid_pad[owner_o] : winner_found;
  assign accept      = ld && grant_valid && !timeout_fire;

  always_comb begin
    grant_word  = '0;
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_word     = req_cmd_i[32*i +: 32];
        req_ready_o[i] = accept;
      end
    end
  end

  assign stop_word = (grant_word[31:28] == STOP_OP);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // A stalled owner is only evicted once the output register can take the synthetic STOP.
  assign timeout_fire = (state == ST_LOCKED) && (wd_cnt == WD_LIMIT) && ld;
`else
  assign timeout_fire = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      owner_o     <= 3'(N_REQ - 1);
      busy_o      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout_o   <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      if (ld) begin
        if (timeout_fire) begin
          cmd_o       <= {STOP_OP, 28'h0};
          cmd_valid_o <= 1'b1;
        end else if (accept) begin
          cmd_o       <= grant_word;
          cmd_valid_o <= 1'b1;
        end else begin
          cmd_valid_o <= 1'b0;
        end
      end

      if (timeout_fire) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else if (accept) begin
        if (state == ST_IDLE) begin
          owner_o <= winner;
          if (!stop_word) begin
            state  <= ST_LOCKED;
            busy_o <= 1'b1;
          end
        end else if (stop_word) begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      end

`ifdef I2C_ARB_TIMEOUT_EN
      timeout_o <= timeout_fire;
      if (state != ST_LOCKED || accept || timeout_fire) begin
        wd_cnt <= '0;
      end else if (!valid_pad[owner_o] && wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_udma_i2c_cmd_arb.sv
// Directed self-checking bench for udma_i2c_cmd_arb (2-requester and 3-requester instances).
module tb_udma_i2c_cmd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] req_cmd;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  owner;
  logic        busy;
  logic        timeout;

  logic [95:0] req_cmd3;
  logic [2:0]  req_valid3;
  logic [2:0]  req_ready3;
  logic [31:0] cmd3;
  logic        cmd_valid3;
  logic        cmd_ready3;
  logic [2:0]  owner3;
  logic        busy3;
  logic        timeout3;

  int tests_run    = 0;
  int tests_failed = 0;

  udma_i2c_cmd_arb #(.N_REQ(2), .STOP_OP(4'h2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_cmd_i(req_cmd), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .cmd_o(cmd), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
  );

  udma_i2c_cmd_arb #(.N_REQ(3), .STOP_OP(4'h2), .TIMEOUT_CYCLES(16)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_cmd_i(req_cmd3), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .cmd_o(cmd3), .cmd_valid_o(cmd_valid3), .cmd_ready_i(cmd_ready3),
    .owner_o(owner3), .busy_o(busy3), .timeout_o(timeout3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] w0, input logic [31:0] w1,
                               input logic crdy);
    req_valid = v;
    req_cmd   = {w1, w0};
    cmd_ready = crdy;
    #1;
  endtask

  task automatic applyStimulus3(input logic [2:0] v, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2);
    req_valid3 = v;
    req_cmd3   = {w2, w1, w0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    cmd_ready3 = 1'b1;
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    applyStimulus3(3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_cmd", 64'(cmd), 64'h0);
    checkOutput("rst_valid", 64'(cmd_valid), 64'h0);
    checkOutput("rst_owner", 64'(owner), 64'h1);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_timeout", 64'(timeout), 64'h0);
    checkOutput("rst_owner3", 64'(owner3), 64'h2);
    rst = 1'b0;

    // req0 three-word transaction while req1 waits
    applyStimulus(2'b11, 32'h0000_0011, 32'h1000_0044, 1'b1);
    checkOutput("a_rdy0", 64'(req_ready), 64'h1);
    tick();
    checkOutput("a_cmd0", 64'(cmd), 64'h0000_0011);
    checkOutput("a_valid0", 64'(cmd_valid), 64'h1);
    checkOutput("a_owner0", 64'(owner), 64'h0);
    checkOutput("a_busy0", 64'(busy), 64'h1);
    applyStimulus(2'b11, 32'h8000_0022, 32'h1000_0044, 1'b1);
    checkOutput("a_rdy1", 64'(req_ready), 64'h1);
    tick();
    checkOutput("a_cmd1", 64'(cmd), 64'h8000_0022);
    checkOutput("a_busy1", 64'(busy), 64'h1);
    applyStimulus(2'b11, 32'h2000_0033, 32'h1000_0044, 1'b1);
    checkOutput("a_rdy2", 64'(req_ready), 64'h1);
    tick();
    checkOutput("a_cmd2", 64'(cmd), 64'h2000_0033);
    checkOutput("a_busy2", 64'(busy), 64'h0);
    checkOutput("a_owner2", 64'(owner), 64'h0);
    applyStimulus(2'b10, 32'h0, 32'h1000_0044, 1'b1);
    checkOutput("a_rdy3", 64'(req_ready), 64'h2);
    tick();
    checkOutput("a_cmd3", 64'(cmd), 64'h1000_0044);
    checkOutput("a_owner3", 64'(owner), 64'h1);
    checkOutput("a_busy3", 64'(busy), 64'h1);

    // Backpressure while req1 holds the lock
    applyStimulus(2'b11, 32'h2000_00A0, 32'h3000_0055, 1'b0);
    checkOutput("c_rdy_stall", 64'(req_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("c_cmd_hold", 64'(cmd), 64'h1000_0044);
      checkOutput("c_valid_hold", 64'(cmd_valid), 64'h1);
      checkOutput("c_busy_hold", 64'(busy), 64'h1);
      checkOutput("c_owner_hold", 64'(owner), 64'h1);
      checkOutput("c_rdy_hold", 64'(req_ready), 64'h0);
    end
    applyStimulus(2'b11, 32'h2000_00A0, 32'h3000_0055, 1'b1);
    checkOutput("c_rdy_resume", 64'(req_ready), 64'h2);
    tick();
    checkOutput("c_cmd_resume", 64'(cmd), 64'h3000_0055);
    checkOutput("c_busy_resume", 64'(busy), 64'h1);
    applyStimulus(2'b11, 32'h2000_00A0, 32'h2000_0077, 1'b1);
    checkOutput("c_rdy_stop", 64'(req_ready), 64'h2);
    tick();
    checkOutput("c_cmd_stop", 64'(cmd), 64'h2000_0077);
    checkOutput("c_busy_stop", 64'(busy), 64'h0);
    checkOutput("c_owner_stop", 64'(owner), 64'h1);

    // STOP-only words from both requesters alternate
    applyStimulus(2'b11, 32'h2000_00A0, 32'h2000_00B1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic exp_owner;
      exp_owner = (i % 2) == 1;
      checkOutput("b_rdy", 64'(req_ready), exp_owner ? 64'h2 : 64'h1);
      tick();
      checkOutput("b_owner", 64'(owner), 64'(exp_owner));
      checkOutput("b_cmd", 64'(cmd), exp_owner ? 64'h2000_00B1 : 64'h2000_00A0);
      checkOutput("b_busy", 64'(busy), 64'h0);
    end

    // A lone requester wins back-to-back
    applyStimulus(2'b01, 32'h2000_00A0, 32'h2000_00B1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("s_rdy", 64'(req_ready), 64'h1);
      tick();
      checkOutput("s_owner", 64'(owner), 64'h0);
      checkOutput("s_valid", 64'(cmd_valid), 64'h1);
    end
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("s_valid_drop", 64'(cmd_valid), 64'h0);

    // Reset in the middle of a locked transaction
    applyStimulus(2'b01, 32'h1000_00C0, 32'h0, 1'b1);
    checkOutput("r_rdy", 64'(req_ready), 64'h1);
    tick();
    checkOutput("r_busy_pre", 64'(busy), 64'h1);
    checkOutput("r_valid_pre", 64'(cmd_valid), 64'h1);
    rst = 1'b1;
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("r_valid", 64'(cmd_valid), 64'h0);
    checkOutput("r_busy", 64'(busy), 64'h0);
    checkOutput("r_owner", 64'(owner), 64'h1);
    checkOutput("r_cmd", 64'(cmd), 64'h0);
    rst = 1'b0;

    // Owner goes silent after START while req1 is pending
    applyStimulus(2'b01, 32'h1000_00D0, 32'h2000_00E1, 1'b1);
    checkOutput("t_rdy_start", 64'(req_ready), 64'h1);
    tick();
    checkOutput("t_busy_start", 64'(busy), 64'h1);
    checkOutput("t_owner_start", 64'(owner), 64'h0);
    applyStimulus(2'b10, 32'h0, 32'h2000_00E1, 1'b1);
    checkOutput("t_rdy_locked", 64'(req_ready), 64'h0);
`ifdef I2C_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      checkOutput("t_no_pulse", 64'(timeout), 64'h0);
      checkOutput("t_busy_wait", 64'(busy), 64'h1);
    end
    tick();
    checkOutput("t_cmd_stop", 64'(cmd), 64'h2000_0000);
    checkOutput("t_valid_stop", 64'(cmd_valid), 64'h1);
    checkOutput("t_pulse", 64'(timeout), 64'h1);
    checkOutput("t_busy_rel", 64'(busy), 64'h0);
    checkOutput("t_owner_rel", 64'(owner), 64'h0);
    checkOutput("t_rdy_next", 64'(req_ready), 64'h2);
    tick();
    checkOutput("t_pulse_end", 64'(timeout), 64'h0);
    checkOutput("t_cmd_next", 64'(cmd), 64'h2000_00E1);
    checkOutput("t_owner_next", 64'(owner), 64'h1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t_no_pulse", 64'(timeout), 64'h0);
      checkOutput("t_busy_hold", 64'(busy), 64'h1);
      checkOutput("t_rdy_hold", 64'(req_ready), 64'h0);
    end
    applyStimulus(2'b11, 32'h2000_00F0, 32'h2000_00E1, 1'b1);
    checkOutput("t_rdy_ownstop", 64'(req_ready), 64'h1);
    tick();
    checkOutput("t_cmd_ownstop", 64'(cmd), 64'h2000_00F0);
    checkOutput("t_busy_ownstop", 64'(busy), 64'h0);
    applyStimulus(2'b10, 32'h0, 32'h2000_00E1, 1'b1);
    checkOutput("t_rdy_next", 64'(req_ready), 64'h2);
    tick();
    checkOutput("t_cmd_next", 64'(cmd), 64'h2000_00E1);
    checkOutput("t_owner_next", 64'(owner), 64'h1);
`endif
    applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);

    // Three requesters: wrap-around from owner 2
    applyStimulus3(3'b100, 32'h0, 32'h0, 32'h2000_0003);
    checkOutput("w_rdy_first", 64'(req_ready3), 64'h4);
    tick();
    checkOutput("w_owner_first", 64'(owner3), 64'h2);
    applyStimulus3(3'b101, 32'h2000_0001, 32'h0, 32'h2000_0003);
    checkOutput("w_rdy_wrap", 64'(req_ready3), 64'h1);
    tick();
    checkOutput("w_owner_wrap", 64'(owner3), 64'h0);
    checkOutput("w_cmd_wrap", 64'(cmd3), 64'h2000_0001);
    checkOutput("w_rdy_skip", 64'(req_ready3), 64'h4);
    tick();
    checkOutput("w_owner_skip", 64'(owner3), 64'h2);
    checkOutput("w_cmd_skip", 64'(cmd3), 64'h2000_0003);
    applyStimulus3(3'b110, 32'h0, 32'h2000_0002, 32'h2000_0003);
    checkOutput("w_rdy_mid", 64'(req_ready3), 64'h2);
    tick();
    checkOutput("w_owner_mid", 64'(owner3), 64'h1);
    checkOutput("w_busy3", 64'(busy3), 64'h0);
    checkOutput("w_timeout3", 64'(timeout3), 64'h0);
    applyStimulus3(3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("w_valid_drop", 64'(cmd_valid3), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
